// File: rtl/cpu_pkg.sv
// Shared processor definitions: opcodes, width defaults,
// and the fetch state encoding.
package cpu_pkg;

  localparam int PC_W_DEF    = 8;
  localparam int INSTR_W_DEF = 8;

  localparam logic [3:0] OP_STOP = 4'h1;
  localparam logic [3:0] OP_NOP  = 4'hA;
  localparam logic [3:0] OP_BR0  = 4'h5;
  localparam logic [3:0] OP_BR1  = 4'h9;
  localparam logic [3:0] OP_BR2  = 4'hD;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry circular FIFO of {pc, instr} for the fetch buffer.
// Ports: push/push_pc/push_instr in, pop, flush in; head_pc/head_instr/count out.
module fetch_fifo2 #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [PC_W-1:0]    push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  output logic [PC_W-1:0]    head_pc,
  output logic [INSTR_W-1:0] head_instr,
  output logic [1:0]         count
);

  logic [1:0][PC_W-1:0]    pc_q, pc_d;
  logic [1:0][INSTR_W-1:0] instr_q, instr_d;
  logic                    wr_q, wr_d;
  logic                    rd_q, rd_d;
  logic [1:0]              count_q, count_d;
  logic                    pop_ok;

  assign pop_ok = pop & (count_q != 2'd0);

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push) begin
        pc_d[wr_q]    = push_pc;
        instr_d[wr_q] = push_instr;
        wr_d          = ~wr_q;
      end
      if (pop_ok) begin
        rd_d = ~rd_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign head_pc    = pc_q[rd_q];
  assign head_instr = instr_q[rd_q];
  assign count      = count_q;

  a_no_overflow: assert property (
    @(posedge clock) disable iff (reset)
    !(push && !pop_ok && !flush && count_q == 2'd2)
  );

endmodule

// File: rtl/pipe_fetch.sv
// Instruction fetch front-end: PC, imem read issue, epoch-tagged
// in-flight tracking, stop/branch handling and a 2-entry buffer to IR1.
// Ports: clock/reset, ir1_load/en_fetch/branch/branch_target from control,
// imem_rd/imem_addr/imem_rdata, ir1_instr/ir1_pc/ir1_valid, fetch_halted.
module pipe_fetch
  import cpu_pkg::*;
#(
  parameter int                 PC_W      = PC_W_DEF,
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(8'h0A)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ir1_load,
  input  logic               en_fetch,
  input  logic               branch,
  input  logic [PC_W-1:0]    branch_target,
  output logic               imem_rd,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir1_instr,
  output logic [PC_W-1:0]    ir1_pc,
  output logic               ir1_valid,
  output logic               fetch_halted
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              epoch_q, epoch_d;
  logic              infl_q, infl_d;
  logic [PC_W-1:0]   infl_addr_q, infl_addr_d;
  logic              infl_epoch_q, infl_epoch_d;

  logic [1:0]         count;
  logic [PC_W-1:0]    head_pc;
  logic [INSTR_W-1:0] head_instr;
  logic               pop;
  logic               cap;
  logic               stop_cap;
  logic [2:0]         occ;
  logic               rd;

  assign ir1_valid = (count != 2'd0);
  assign pop       = ir1_valid & ir1_load & en_fetch & ~branch;

  // A stale-epoch or same-cycle-branch response is dropped.
  assign cap      = infl_q & (infl_epoch_q == epoch_q) & ~branch;
  assign stop_cap = cap & (imem_rdata[3:0] == OP_STOP);

  // The in-flight response lands this edge, so it counts as occupancy.
  assign occ = {1'b0, count} - {2'b0, pop} + {2'b0, infl_q};

  // Nothing is read once a stop has been seen, even in its capture cycle.
  assign rd = (state_q == S_RUN) & en_fetch & ~branch
            & ~stop_cap & (occ < 3'd2);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    epoch_d      = epoch_q;
    infl_d       = rd;
    infl_addr_d  = infl_addr_q;
    infl_epoch_d = infl_epoch_q;
    unique case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   if (stop_cap) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    if (rd) begin
      pc_d         = pc_q + PC_W'(1);
      infl_addr_d  = pc_q;
      infl_epoch_d = epoch_q;
    end
    if (branch) begin
      state_d = S_RUN;
      pc_d    = branch_target;
      epoch_d = ~epoch_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      epoch_q      <= 1'b0;
      infl_q       <= 1'b0;
      infl_addr_q  <= '0;
      infl_epoch_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epoch_q      <= epoch_d;
      infl_q       <= infl_d;
      infl_addr_q  <= infl_addr_d;
      infl_epoch_q <= infl_epoch_d;
    end
  end

  fetch_fifo2 #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (cap),
    .pop        (pop),
    .flush      (branch),
    .push_pc    (infl_addr_q),
    .push_instr (imem_rdata),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .count      (count)
  );

  assign imem_rd      = rd;
  assign imem_addr    = pc_q;
  assign ir1_instr    = ir1_valid ? head_instr : NOP_INSTR;
  assign ir1_pc       = ir1_valid ? head_pc : '0;
  assign fetch_halted = (state_q == S_HALT) & ~infl_q;

endmodule

// File: tb/tb_pipe_fetch.sv
// Directed bench for pipe_fetch: per-cycle vector tables
// plus hand sequences for stop/resume and async reset.
module tb_pipe_fetch;

  logic       clock = 1'b0;
  logic       reset;
  logic       ir1_load;
  logic       en_fetch;
  logic       branch;
  logic [7:0] branch_target;
  logic       imem_rd;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic [7:0] ir1_instr;
  logic [7:0] ir1_pc;
  logic       ir1_valid;
  logic       fetch_halted;

  logic [7:0] mem [256];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       ld;
    logic       en;
    logic       br;
    logic [7:0] tgt;
    logic       rd;
    logic [7:0] addr;
    logic       vld;
    logic [7:0] ins;
    logic [7:0] pc;
    logic       hlt;
  } vec_t;

  vec_t tab[$];

  pipe_fetch dut (
    .clock         (clock),
    .reset         (reset),
    .ir1_load      (ir1_load),
    .en_fetch      (en_fetch),
    .branch        (branch),
    .branch_target (branch_target),
    .imem_rd       (imem_rd),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .ir1_instr     (ir1_instr),
    .ir1_pc        (ir1_pc),
    .ir1_valid     (ir1_valid),
    .fetch_halted  (fetch_halted)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (imem_rd) imem_rdata <= mem[imem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp,
               $time);
    end
  endtask

  function automatic vec_t mk(logic ld, logic en, logic br,
                              logic [7:0] tgt, logic rd,
                              logic [7:0] addr, logic vld,
                              logic [7:0] ins, logic [7:0] pc,
                              logic hlt);
    vec_t v;
    v.ld = ld; v.en = en; v.br = br; v.tgt = tgt;
    v.rd = rd; v.addr = addr; v.vld = vld;
    v.ins = ins; v.pc = pc; v.hlt = hlt;
    return v;
  endfunction

  task automatic check_reset_outs(input string tag);
    chk({tag, "_rd"}, 32'(imem_rd), 0);
    chk({tag, "_addr"}, 32'(imem_addr), 0);
    chk({tag, "_vld"}, 32'(ir1_valid), 0);
    chk({tag, "_ins"}, 32'(ir1_instr), 32'h0A);
    chk({tag, "_pc"}, 32'(ir1_pc), 0);
    chk({tag, "_hlt"}, 32'(fetch_halted), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ir1_load = 1'b1;
    en_fetch = 1'b1;
    branch = 1'b0;
    branch_target = 8'h00;
    @(posedge clock);
    #1;
    check_reset_outs("rst");
    reset = 1'b0;
  endtask

  task automatic run_tab(input string tag);
    foreach (tab[i]) begin
      ir1_load = tab[i].ld;
      en_fetch = tab[i].en;
      branch = tab[i].br;
      branch_target = tab[i].tgt;
      #1;
      chk($sformatf("%s[%0d]_rd", tag, i), 32'(imem_rd), 32'(tab[i].rd));
      if (tab[i].rd)
        chk($sformatf("%s[%0d]_addr", tag, i), 32'(imem_addr),
            32'(tab[i].addr));
      chk($sformatf("%s[%0d]_vld", tag, i), 32'(ir1_valid),
          32'(tab[i].vld));
      chk($sformatf("%s[%0d]_ins", tag, i), 32'(ir1_instr),
          32'(tab[i].ins));
      chk($sformatf("%s[%0d]_pc", tag, i), 32'(ir1_pc), 32'(tab[i].pc));
      chk($sformatf("%s[%0d]_hlt", tag, i), 32'(fetch_halted),
          32'(tab[i].hlt));
      @(posedge clock);
      #1;
    end
    tab.delete();
  endtask

  task automatic init_mem();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = 8'(i);
      mem[i] = {a[3:0], 4'h2};
    end
    mem[0] = 8'h04;
    mem[1] = 8'h06;
    mem[2] = 8'h08;
    mem[3] = 8'h0A;
  endtask

  initial begin
    reset = 1'b1;
    ir1_load = 1'b0;
    en_fetch = 1'b0;
    branch = 1'b0;
    branch_target = 8'h00;
    init_mem();
    #2;
    check_reset_outs("por");

    // Stream, stall, branch, wrap, fetch disable.
    do_reset();
    //            ld en br tgt   rd addr  vld ins    pc     hlt
    tab.push_back(mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 8'h0A, 8'h00, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h00, 0, 8'h0A, 8'h00, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h01, 0, 8'h0A, 8'h00, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h02, 1, 8'h04, 8'h00, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h03, 1, 8'h06, 8'h01, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h04, 1, 8'h08, 8'h02, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h05, 1, 8'h0A, 8'h03, 0));
    for (int k = 0; k < 5; k++)
      tab.push_back(mk(0, 1, 0, 8'h00, 0, 8'h06, 1, 8'h42, 8'h04, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h06, 1, 8'h42, 8'h04, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h07, 1, 8'h52, 8'h05, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h08, 1, 8'h62, 8'h06, 0));
    tab.push_back(mk(1, 1, 1, 8'h20, 0, 8'h09, 1, 8'h72, 8'h07, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h20, 0, 8'h0A, 8'h00, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h21, 0, 8'h0A, 8'h00, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h22, 1, 8'h02, 8'h20, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h23, 1, 8'h12, 8'h21, 0));
    tab.push_back(mk(1, 1, 1, 8'hFF, 0, 8'h24, 1, 8'h22, 8'h22, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'hFF, 0, 8'h0A, 8'h00, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h00, 0, 8'h0A, 8'h00, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h01, 1, 8'hF2, 8'hFF, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h02, 1, 8'h04, 8'h00, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h03, 1, 8'h06, 8'h01, 0));
    tab.push_back(mk(1, 0, 0, 8'h00, 0, 8'h04, 1, 8'h08, 8'h02, 0));
    tab.push_back(mk(1, 0, 0, 8'h00, 0, 8'h04, 1, 8'h08, 8'h02, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h04, 1, 8'h08, 8'h02, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h05, 1, 8'h0A, 8'h03, 0));
    run_tab("main");

    // Stop at address 2, drain, halt, then resume by branch to 0.
    mem[2] = 8'h01;
    do_reset();
    tab.push_back(mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 8'h0A, 8'h00, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h00, 0, 8'h0A, 8'h00, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h01, 0, 8'h0A, 8'h00, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h02, 1, 8'h04, 8'h00, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 0, 8'h03, 1, 8'h06, 8'h01, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 0, 8'h03, 1, 8'h01, 8'h02, 1));
    tab.push_back(mk(1, 1, 0, 8'h00, 0, 8'h03, 0, 8'h0A, 8'h00, 1));
    tab.push_back(mk(1, 1, 0, 8'h00, 0, 8'h03, 0, 8'h0A, 8'h00, 1));
    tab.push_back(mk(1, 1, 1, 8'h00, 0, 8'h03, 0, 8'h0A, 8'h00, 1));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h00, 0, 8'h0A, 8'h00, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h01, 0, 8'h0A, 8'h00, 0));
    tab.push_back(mk(1, 1, 0, 8'h00, 1, 8'h02, 1, 8'h04, 8'h00, 0));
    run_tab("stop");
    mem[2] = 8'h08;

    // Fill the buffer under stall, then assert reset between edges.
    do_reset();
    tab.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h0A, 8'h00, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 1, 8'h00, 0, 8'h0A, 8'h00, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 1, 8'h01, 0, 8'h0A, 8'h00, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 0, 8'h02, 1, 8'h04, 8'h00, 0));
    tab.push_back(mk(0, 1, 0, 8'h00, 0, 8'h02, 1, 8'h04, 8'h00, 0));
    run_tab("full");
    ir1_load = 1'b1;
    #1;
    chk("pre_async_rd", 32'(imem_rd), 1);
    reset = 1'b1;
    #1;
    check_reset_outs("async");
    @(posedge clock);
    #1;
    check_reset_outs("async_hold");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: test did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
